// File: rtl/mon_pkg.sv
// mon_pkg: state encoding and saturating-increment helper shared by halt_dump_monitor.
package mon_pkg;
    typedef enum logic [1:0] {MON_RUN, MON_DUMP, MON_DONE} mon_state_t;
    localparam int unsigned SAT_MAX_W = 64;
    // Counters up to SAT_MAX_W bits pass through this at their own width w.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v, input int unsigned w);
        logic [SAT_MAX_W-1:0] lim;
        lim = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (v == lim) ? v : v + SAT_MAX_W'(1);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: enable/clear counter that sticks at all-ones instead of wrapping.
module sat_counter
    import mon_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_d, cnt_q;
    always_comb cnt_d = clr ? '0 : en ? WIDTH'(sat_inc(SAT_MAX_W'(cnt_q), WIDTH)) : cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/halt_dump_monitor.sv
// halt_dump_monitor: counts run cycles/events, then streams the register file on halt or watchdog.
// Optional MON_SKIP_ZERO_EN: zero-valued registers are skipped without a beat.
module halt_dump_monitor
    import mon_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int NUM_EVT    = 4,
    parameter int TIMEOUT    = 0,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         is_halted,
    input  logic [NUM_EVT-1:0]           evt_pulse,
    output logic [AW-1:0]                rf_addr,
    input  logic [DATA_WIDTH-1:0]        rf_rdata,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic [AW-1:0]                dump_idx,
    output logic [DATA_WIDTH-1:0]        dump_data,
    output logic [CNT_WIDTH-1:0]         total_cycle,
    output logic [NUM_EVT*CNT_WIDTH-1:0] evt_count,
    output logic                         timed_out,
    output logic                         done
);
    mon_state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic timed_out_q, timed_out_d, done_q, done_d;
    logic run, wd_hit, adv, last;

    assign run    = state_q == MON_RUN;
    assign wd_hit = (TIMEOUT != 0) && !is_halted && (total_cycle == CNT_WIDTH'(TIMEOUT - 1));
    assign last   = idx_q == AW'(NUM_REGS - 1);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cyc (
        .clk(clk), .reset(reset), .en(run && !is_halted), .clr(1'b0), .cnt(total_cycle)
    );

    for (genvar i = 0; i < NUM_EVT; i++) begin : g_evt
        sat_counter #(.WIDTH(CNT_WIDTH)) u_evt (
            .clk(clk), .reset(reset), .en(run && evt_pulse[i]), .clr(1'b0),
            .cnt(evt_count[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

`ifdef MON_SKIP_ZERO_EN
    assign dump_valid = (state_q == MON_DUMP) && (rf_rdata != '0);
`else
    assign dump_valid = state_q == MON_DUMP;
`endif
    // An index moves on when its beat is accepted or when there is no beat to present.
    assign adv = (state_q == MON_DUMP) && (dump_ready || !dump_valid);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timed_out_d = timed_out_q;
        done_d      = done_q;
        if (run && (is_halted || wd_hit)) begin
            state_d     = MON_DUMP;
            timed_out_d = !is_halted;
        end
        if (adv) begin
            idx_d = idx_q + AW'(1);
            if (last) begin
                state_d = MON_DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MON_RUN;
            idx_q       <= '0;
            timed_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timed_out_q <= timed_out_d;
            done_q      <= done_d;
        end
    end

    assign rf_addr   = idx_q;
    assign dump_idx  = idx_q;
    assign dump_data = dump_valid ? rf_rdata : '0;
    assign timed_out = timed_out_q;
    assign done      = done_q;
endmodule

// File: tb/tb_halt_dump_monitor.sv
// tb_halt_dump_monitor: randomized bench with a spec-level model of counts, trigger and beat stream.
module tb_halt_dump_monitor;
    localparam int NR = 32, DW = 32, CW = 32, NE = 4, TO = 16;
`ifdef MON_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic is_halted = 1'b0;
    logic dump_ready = 1'b0;
    logic [NE-1:0] evt_pulse = '0;
    logic [4:0] rf_addr, dump_idx;
    logic [DW-1:0] rf_rdata, dump_data;
    logic dump_valid, timed_out, done;
    logic [CW-1:0] total_cycle;
    logic [NE*CW-1:0] evt_count;
    logic [DW-1:0] rf [NR];

    logic [1:0] s_addr, s_idx;
    logic [7:0] s_rdata, s_data;
    logic [3:0] s_evt, s_total;
    logic [15:0] s_evt_count;
    logic s_valid, s_to, s_done;

    int n_vec = 0;
    int n_err = 0;

    assign rf_rdata = rf[rf_addr];
    assign s_rdata  = 8'h00;
    assign s_evt    = 4'b0101;

    always #5 clk = ~clk;

    halt_dump_monitor #(.NUM_REGS(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .NUM_EVT(NE), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .is_halted(is_halted), .evt_pulse(evt_pulse),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .total_cycle(total_cycle),
        .evt_count(evt_count), .timed_out(timed_out), .done(done)
    );

    halt_dump_monitor #(.NUM_REGS(4), .DATA_WIDTH(8), .CNT_WIDTH(4), .NUM_EVT(4), .TIMEOUT(0)) dut_s (
        .clk(clk), .reset(reset), .is_halted(1'b0), .evt_pulse(s_evt),
        .rf_addr(s_addr), .rf_rdata(s_rdata), .dump_valid(s_valid), .dump_ready(1'b1),
        .dump_idx(s_idx), .dump_data(s_data), .total_cycle(s_total),
        .evt_count(s_evt_count), .timed_out(s_to), .done(s_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        is_halted = 1'b0;
        evt_pulse = '0;
        dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", dump_valid, 0);
        check("rst_total", total_cycle, 0);
        check("rst_evt", evt_count, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
    endtask

    // halt_edge: edge (1-based after release) where is_halted is first sampled high; 0 = never.
    // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. abort_beat: reset after that many beats.
    task automatic run_case(input string name, input int halt_edge, input int rdy_mode,
                            input int abort_beat, input bit rand_evt, input logic [NE-1:0] pat);
        int trig, beats, cyc;
        bit halt_wins;
        int ev_exp [NE];
        int exp_i [$];
        logic [DW-1:0] exp_d [$];
        logic [NE-1:0] p;
        logic pend, stall;
        logic [4:0] pend_idx;
        logic [DW-1:0] pend_data;
        logic [CW-1:0] tot_snap;
        logic [NE*CW-1:0] ev_snap;
        halt_wins = (halt_edge != 0) && (halt_edge <= TO);
        trig = halt_wins ? halt_edge : TO;
        for (int i = 0; i < NE; i++) ev_exp[i] = 0;
        for (int r = 0; r < NR; r++)
            if (!SKIP || rf[r] != 0) begin
                exp_i.push_back(r);
                exp_d.push_back(rf[r]);
            end
        for (int e = 1; e <= trig; e++) begin
            is_halted = (halt_edge != 0) && (e >= halt_edge);
            p = rand_evt ? NE'($urandom) : pat;
            evt_pulse = p;
            for (int i = 0; i < NE; i++) if (p[i]) ev_exp[i]++;
            if (e == trig) begin
                check({name, "_pre_total"}, total_cycle, trig - 1);
                check({name, "_run_valid"}, dump_valid, 0);
                check({name, "_run_addr"}, rf_addr, 0);
            end
            @(posedge clk);
            #1;
        end
        check({name, "_total"}, total_cycle, halt_wins ? trig - 1 : TO);
        check({name, "_timed_out"}, timed_out, !halt_wins);
        for (int i = 0; i < NE; i++) check({name, "_evt"}, evt_count[i*CW +: CW], ev_exp[i]);
        tot_snap = total_cycle;
        ev_snap = evt_count;
        beats = 0;
        stall = 1'b0;
        cyc = 0;
        while (cyc < 600 && !done) begin
            if (stall) begin
                check({name, "_stall_valid"}, dump_valid, 1);
                check({name, "_stall_idx"}, dump_idx, pend_idx);
                check({name, "_stall_data"}, dump_data, pend_data);
            end
            dump_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom);
            is_halted = 1'($urandom);
            evt_pulse = NE'($urandom);
            if (dump_valid) check({name, "_data_vs_rf"}, dump_data, rf[dump_idx]);
            pend = dump_valid && dump_ready;
            stall = dump_valid && !dump_ready;
            pend_idx = dump_idx;
            pend_data = dump_data;
            @(posedge clk);
            #1;
            cyc++;
            if (pend) begin
                beats++;
                if (exp_i.size() == 0) check({name, "_extra_beat"}, 1, 0);
                else begin
                    check({name, "_beat_idx"}, pend_idx, exp_i.pop_front());
                    check({name, "_beat_data"}, pend_data, exp_d.pop_front());
                end
                if (abort_beat != 0 && beats == abort_beat) begin
                    reset = 1'b0;
                    #1;
                    check({name, "_abort_valid"}, dump_valid, 0);
                    check({name, "_abort_total"}, total_cycle, 0);
                    check({name, "_abort_evt"}, evt_count, 0);
                    check({name, "_abort_idx"}, dump_idx, 0);
                    check({name, "_abort_done"}, done, 0);
                    return;
                end
            end
        end
        check({name, "_done"}, done, 1);
        check({name, "_beats_left"}, exp_i.size(), 0);
        if (rdy_mode == 0) check({name, "_dump_cycles"}, cyc, NR);
        for (int k = 0; k < 4; k++) begin
            is_halted = 1'($urandom);
            evt_pulse = NE'($urandom);
            dump_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check({name, "_done_sticky"}, done, 1);
        check({name, "_done_valid"}, dump_valid, 0);
        check({name, "_frozen_total"}, total_cycle, tot_snap);
        check({name, "_frozen_evt"}, evt_count, ev_snap);
        check({name, "_final_to"}, timed_out, !halt_wins);
    endtask

    task automatic fill_rf();
        for (int r = 0; r < NR; r++) rf[r] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
    endtask

    initial begin
        fill_rf();
        do_reset();
        run_case("halt9", 9, 0, 0, 1'b1, '0);
        do_reset();
        run_case("events", 11, 1, 0, 1'b0, 4'b0101);
        do_reset();
        run_case("wdog", 0, 2, 0, 1'b1, '0);
        do_reset();
        run_case("wd_tie", TO, 2, 0, 1'b1, '0);
        do_reset();
        run_case("abort", 5, 0, 5, 1'b1, '0);
        for (int r = 0; r < NR; r++) rf[r] = '0;
        rf[2] = 32'hdead_0002;
        rf[31] = 32'h1234_5031;
        do_reset();
        run_case("sparse", 3, 0, 0, 1'b1, '0);
        for (int r = 0; r < NR; r++) rf[r] = '0;
        do_reset();
        run_case("allzero", 2, 0, 0, 1'b1, '0);
        for (int t = 0; t < 3; t++) begin
            fill_rf();
            do_reset();
            run_case("rand", $urandom_range(1, 20), 2, 0, 1'b1, '0);
        end
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        check("sat_total", s_total, 15);
        check("sat_evt0", s_evt_count[3:0], 15);
        check("sat_evt1", s_evt_count[7:4], 0);
        check("sat_evt2", s_evt_count[11:8], 15);
        check("sat_valid", s_valid, 0);
        check("sat_done", s_done, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
